// File: rtl/usb_fifo_arbiter.sv
`timescale 1ns/1ps
// CY68013 slave-FIFO bus arbiter: round-robin EP2 reads / EP6 writes with bounded
// bursts, programmable setup/strobe/hold widths, and ownership of the usb_fd bus.
module usb_fifo_arbiter #(
   parameter int SETUP_CYC  = 2,
   parameter int STROBE_CYC = 4,
   parameter int HOLD_CYC   = 3,
   parameter int BURST_MAX  = 16
) (
   input  logic        fpga_gclk,
   input  logic        reset_n,
   input  logic        usb_flaga,
   input  logic        usb_flagc,
   output logic [1:0]  usb_fifoaddr,
   output logic        usb_slcs,
   output logic        usb_sloe,
   output logic        usb_slrd,
   output logic        usb_slwr,
   inout  wire  [15:0] usb_fd,
   input  logic        rx_en,
   input  logic        rx_ready,
   output logic [15:0] rx_data,
   output logic        rx_valid,
   input  logic        tx_valid,
   input  logic [15:0] tx_data,
   output logic        tx_ready,
   output logic        busy,
   output logic [15:0] rd_count,
   output logic [15:0] wr_count
);

   typedef enum logic [2:0] {
      IDLE, RD_SETUP, RD_STROBE, RD_HOLD, WR_SETUP, WR_STROBE, WR_HOLD, TURN
   } state_t;

   localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYC - 1);
   localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYC - 1);
   localparam logic [3:0] HOLD_LAST   = 4'(HOLD_CYC - 1);
   localparam logic [8:0] BURST_LAST  = 9'(BURST_MAX - 1);
   localparam logic [1:0] ADDR_EP2    = 2'b00;
   localparam logic [1:0] ADDR_EP6    = 2'b10;
   localparam logic       DIR_RD      = 1'b0;
   localparam logic       DIR_WR      = 1'b1;

   state_t      state, state_nxt;
   logic [3:0]  phase_cnt, phase_cnt_nxt;
   logic [8:0]  burst_cnt, burst_cnt_nxt;
   logic        last_dir, last_dir_nxt;
   logic [1:0]  fifoaddr_nxt;
   logic        flaga_m, flaga_s, flagc_m, flagc_s;
   logic        rd_elig, wr_elig;
   logic        rd_sample, wr_load, wr_done;
   logic        fd_oe;
   logic [15:0] wr_word;

   assign rd_elig  = flaga_s & rx_en & rx_ready;
   assign wr_elig  = flagc_s & tx_valid;
   assign usb_slcs = 1'b0;
   assign usb_fd   = fd_oe ? wr_word : 16'hzzzz;

   always_ff @(posedge fpga_gclk or negedge reset_n) begin
      if (!reset_n) begin
         flaga_m <= 1'b0;
         flaga_s <= 1'b0;
         flagc_m <= 1'b0;
         flagc_s <= 1'b0;
      end else begin
         flaga_m <= usb_flaga;
         flaga_s <= flaga_m;
         flagc_m <= usb_flagc;
         flagc_s <= flagc_m;
      end
   end

   always_comb begin
      state_nxt     = state;
      phase_cnt_nxt = phase_cnt + 4'd1;
      burst_cnt_nxt = burst_cnt;
      last_dir_nxt  = last_dir;
      fifoaddr_nxt  = usb_fifoaddr;
      rd_sample     = 1'b0;
      wr_load       = 1'b0;
      wr_done       = 1'b0;
      case (state)
         IDLE: begin
            phase_cnt_nxt = '0;
            // On contention the direction not served last goes first.
            if (rd_elig && (!wr_elig || last_dir == DIR_WR)) begin
               state_nxt     = RD_SETUP;
               fifoaddr_nxt  = ADDR_EP2;
               burst_cnt_nxt = '0;
            end else if (wr_elig) begin
               state_nxt     = WR_SETUP;
               fifoaddr_nxt  = ADDR_EP6;
               burst_cnt_nxt = '0;
               wr_load       = 1'b1;
            end
         end
         RD_SETUP:
            if (phase_cnt == SETUP_LAST) begin
               state_nxt     = RD_STROBE;
               phase_cnt_nxt = '0;
            end
         RD_STROBE:
            if (phase_cnt == STROBE_LAST) begin
               state_nxt     = RD_HOLD;
               phase_cnt_nxt = '0;
               rd_sample     = 1'b1;
            end
         RD_HOLD:
            if (phase_cnt == HOLD_LAST) begin
               phase_cnt_nxt = '0;
               burst_cnt_nxt = burst_cnt + 9'd1;
               if (rd_elig && burst_cnt < BURST_LAST) begin
                  state_nxt = RD_SETUP;
               end else begin
                  state_nxt    = TURN;
                  last_dir_nxt = DIR_RD;
               end
            end
         WR_SETUP:
            if (phase_cnt == SETUP_LAST) begin
               state_nxt     = WR_STROBE;
               phase_cnt_nxt = '0;
            end
         WR_STROBE:
            if (phase_cnt == STROBE_LAST) begin
               state_nxt     = WR_HOLD;
               phase_cnt_nxt = '0;
               wr_done       = 1'b1;
            end
         WR_HOLD:
            if (phase_cnt == HOLD_LAST) begin
               phase_cnt_nxt = '0;
               burst_cnt_nxt = burst_cnt + 9'd1;
               if (wr_elig && burst_cnt < BURST_LAST) begin
                  state_nxt = WR_SETUP;
                  wr_load   = 1'b1;
               end else begin
                  state_nxt    = TURN;
                  last_dir_nxt = DIR_WR;
               end
            end
         TURN: begin
            state_nxt     = IDLE;
            phase_cnt_nxt = '0;
         end
         default: begin
            state_nxt     = IDLE;
            phase_cnt_nxt = '0;
         end
      endcase
   end

   // Pins are decoded from the next state so every output leaves a flop.
   always_ff @(posedge fpga_gclk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         phase_cnt    <= '0;
         burst_cnt    <= '0;
         last_dir     <= DIR_WR;
         usb_fifoaddr <= ADDR_EP2;
         usb_sloe     <= 1'b1;
         usb_slrd     <= 1'b1;
         usb_slwr     <= 1'b1;
         fd_oe        <= 1'b0;
         wr_word      <= '0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         tx_ready     <= 1'b0;
         busy         <= 1'b0;
         rd_count     <= '0;
         wr_count     <= '0;
      end else begin
         state        <= state_nxt;
         phase_cnt    <= phase_cnt_nxt;
         burst_cnt    <= burst_cnt_nxt;
         last_dir     <= last_dir_nxt;
         usb_fifoaddr <= fifoaddr_nxt;
         usb_sloe     <= !(state_nxt inside {RD_SETUP, RD_STROBE, RD_HOLD});
         usb_slrd     <= !(state_nxt == RD_STROBE);
         usb_slwr     <= !(state_nxt == WR_STROBE);
         fd_oe        <= state_nxt inside {WR_SETUP, WR_STROBE, WR_HOLD};
         busy         <= (state_nxt != IDLE);
         tx_ready     <= wr_load;
         rx_valid     <= rd_sample;
         if (wr_load) begin
            wr_word <= tx_data;
         end
         if (rd_sample) begin
            rx_data  <= usb_fd;
            rd_count <= rd_count + 16'd1;
         end
         if (wr_done) begin
            wr_count <= wr_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_usb_fifo_arbiter.sv
`timescale 1ns/1ps
// Directed bench for usb_fifo_arbiter: FX2-side environment, word-position reference
// model compared every cycle, plus literal expectations per scenario.
module tb_usb_fifo_arbiter;
   localparam int S = 2, T = 4, H = 3, BMAX = 2;
   localparam int P = S + T + H;

   logic        fpga_gclk;
   logic        reset_n;
   logic        usb_flaga, usb_flagc;
   logic [1:0]  usb_fifoaddr;
   logic        usb_slcs, usb_sloe, usb_slrd, usb_slwr;
   wire  [15:0] usb_fd;
   logic        rx_en, rx_ready, rx_valid;
   logic [15:0] rx_data;
   logic        tx_valid, tx_ready, busy;
   logic [15:0] tx_data, rd_count, wr_count;

   usb_fifo_arbiter #(.SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H), .BURST_MAX(BMAX)) dut (
      .fpga_gclk(fpga_gclk), .reset_n(reset_n), .usb_flaga(usb_flaga), .usb_flagc(usb_flagc),
      .usb_fifoaddr(usb_fifoaddr), .usb_slcs(usb_slcs), .usb_sloe(usb_sloe), .usb_slrd(usb_slrd),
      .usb_slwr(usb_slwr), .usb_fd(usb_fd), .rx_en(rx_en), .rx_ready(rx_ready), .rx_data(rx_data),
      .rx_valid(rx_valid), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .busy(busy), .rd_count(rd_count), .wr_count(wr_count));

   initial fpga_gclk = 1'b0;
   always #10 fpga_gclk = ~fpga_gclk;

   // FX2 side and client side of the environment
   logic [15:0] ep2[$], ep6[$], txq[$];
   logic        flaga_en, tx_en;
   logic [15:0] fx_head;
   logic        slrd_q, slwr_q;

   assign usb_fd = usb_sloe ? 16'hzzzz : fx_head;

   always @(negedge fpga_gclk) begin
      if (slrd_q === 1'b0 && usb_slrd === 1'b1 && ep2.size() > 0) void'(ep2.pop_front());
      if (slwr_q === 1'b0 && usb_slwr === 1'b1) ep6.push_back(usb_fd);
      if (tx_ready === 1'b1 && txq.size() > 0) void'(txq.pop_front());
      slrd_q    = usb_slrd;
      slwr_q    = usb_slwr;
      usb_flaga = flaga_en && (ep2.size() > 0);
      fx_head   = (ep2.size() > 0) ? ep2[0] : 16'hFFFF;
      tx_valid  = tx_en && (txq.size() > 0);
      tx_data   = (txq.size() > 0) ? txq[0] : 16'h0000;
   end

   int n_checks, n_errors;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: mode 0 idle, 1 reading a word, 2 writing a word, 3 turnaround
   int          m_mode, m_pos, m_burst;
   logic        m_lastw, m_as1, m_as, m_cs1, m_cs, m_re, m_we, m_rxv, m_txr;
   logic [15:0] m_rx, m_wd, m_rdc, m_wrc;
   logic [1:0]  m_addr;

   always @(posedge fpga_gclk or negedge reset_n) begin
      if (!reset_n) begin
         m_mode = 0; m_pos = 0; m_burst = 0; m_lastw = 1'b1;
         m_as1 = 0; m_as = 0; m_cs1 = 0; m_cs = 0;
         m_rxv = 0; m_txr = 0; m_rx = 0; m_wd = 0; m_rdc = 0; m_wrc = 0; m_addr = 2'b00;
      end else begin
         m_re  = m_as && rx_en && rx_ready;
         m_we  = m_cs && tx_valid;
         m_rxv = 0;
         m_txr = 0;
         case (m_mode)
            0: if (m_re && (!m_we || m_lastw)) begin
                  m_mode = 1; m_pos = 0; m_burst = 0; m_addr = 2'b00;
               end else if (m_we) begin
                  m_mode = 2; m_pos = 0; m_burst = 0; m_addr = 2'b10; m_wd = tx_data; m_txr = 1;
               end
            1, 2: begin
               if (m_mode == 1 && m_pos == S + T - 1) begin
                  m_rx = fx_head; m_rxv = 1; m_rdc = m_rdc + 16'd1;
               end
               if (m_pos == P - 1) begin
                  m_burst++;
                  if ((m_mode == 1 ? m_re : m_we) && m_burst < BMAX) begin
                     m_pos = 0;
                     if (m_mode == 2) begin m_wd = tx_data; m_txr = 1; end
                  end else begin
                     m_lastw = (m_mode == 2);
                     m_mode  = 3;
                  end
               end else begin
                  m_pos++;
                  if (m_mode == 2 && m_pos == S + T) m_wrc = m_wrc + 16'd1;
               end
            end
            default: m_mode = 0;
         endcase
         m_as = m_as1; m_as1 = usb_flaga;
         m_cs = m_cs1; m_cs1 = usb_flagc;
      end
   end

   // Per-cycle comparison and transaction logging
   logic [15:0] rx_log[$];
   bit          ord_log[$];
   int          slrd_runs[$];
   int          slrd_run, wr_strobes;
   logic        slwr_prev;

   always @(posedge fpga_gclk) begin
      #1;
      chk("sloe", 32'(usb_sloe), 32'(m_mode != 1));
      chk("slrd", 32'(usb_slrd), 32'(!(m_mode == 1 && m_pos >= S && m_pos < S + T)));
      chk("slwr", 32'(usb_slwr), 32'(!(m_mode == 2 && m_pos >= S && m_pos < S + T)));
      chk("slcs", 32'(usb_slcs), 32'(0));
      chk("fifoaddr", 32'(usb_fifoaddr), 32'(m_addr));
      chk("busy", 32'(busy), 32'(m_mode != 0));
      chk("tx_ready", 32'(tx_ready), 32'(m_txr));
      chk("rx_valid", 32'(rx_valid), 32'(m_rxv));
      chk("rx_data", 32'(rx_data), 32'(m_rx));
      chk("rd_count", 32'(rd_count), 32'(m_rdc));
      chk("wr_count", 32'(wr_count), 32'(m_wrc));
      if (m_mode == 2) chk("fd_write", 32'(usb_fd), 32'(m_wd));
      else if (m_mode == 1) chk("fd_read", 32'(usb_fd), 32'(fx_head));
      if (rx_valid) begin rx_log.push_back(rx_data); ord_log.push_back(1'b0); end
      if (tx_ready) ord_log.push_back(1'b1);
      if (!usb_slrd) slrd_run++;
      else if (slrd_run > 0) begin slrd_runs.push_back(slrd_run); slrd_run = 0; end
      if (!usb_slwr && slwr_prev) wr_strobes++;
      slwr_prev = usb_slwr;
   end

   task automatic run(input int n);
      repeat (n) @(negedge fpga_gclk);
   endtask

   task automatic clear_logs();
      rx_log.delete(); ord_log.delete(); slrd_runs.delete(); ep6.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   int got, base, ok;

   initial begin
      n_checks = 0; n_errors = 0;
      reset_n = 1'b0; usb_flagc = 1'b0; rx_en = 1'b0; rx_ready = 1'b0;
      flaga_en = 1'b0; tx_en = 1'b0; slrd_run = 0; wr_strobes = 0; slwr_prev = 1'b1;
      run(3);
      chk("rst_fifoaddr", 32'(usb_fifoaddr), 32'h0);
      chk("rst_slcs", 32'(usb_slcs), 32'h0);
      chk("rst_sloe", 32'(usb_sloe), 32'h1);
      chk("rst_slrd", 32'(usb_slrd), 32'h1);
      chk("rst_slwr", 32'(usb_slwr), 32'h1);
      chk("rst_rx_data", 32'(rx_data), 32'h0);
      chk("rst_rx_valid", 32'(rx_valid), 32'h0);
      chk("rst_tx_ready", 32'(tx_ready), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_counts", {rd_count, wr_count}, 32'h0);
      reset_n = 1'b1;
      run(3);

      // Read only: three words, burst of two then a fresh grant
      clear_logs();
      rx_en = 1'b1; rx_ready = 1'b1;
      ep2.push_back(16'h1234); ep2.push_back(16'h5678); ep2.push_back(16'h9ABC);
      flaga_en = 1'b1;
      run(60);
      chk("t1_nwords", 32'(rx_log.size()), 32'd3);
      for (int i = 0; i < 3; i++) begin
         got = (i < rx_log.size()) ? int'(rx_log[i]) : -1;
         chk("t1_rx_word", 32'(got), (i == 0) ? 32'h1234 : (i == 1) ? 32'h5678 : 32'h9ABC);
         got = (i < slrd_runs.size()) ? slrd_runs[i] : -1;
         chk("t1_slrd_width", 32'(got), 32'd4);
      end
      chk("t1_rd_count", 32'(rd_count), 32'd3);
      chk("t1_fifoaddr", 32'(usb_fifoaddr), 32'h0);
      chk("t1_busy", 32'(busy), 32'h0);
      flaga_en = 1'b0;

      // Write only
      clear_logs();
      usb_flagc = 1'b1;
      txq.push_back(16'hA5A5); txq.push_back(16'h5A5A);
      tx_en = 1'b1;
      run(50);
      chk("t2_nwords", 32'(ep6.size()), 32'd2);
      got = (ep6.size() > 0) ? int'(ep6[0]) : -1;
      chk("t2_word0", 32'(got), 32'hA5A5);
      got = (ep6.size() > 1) ? int'(ep6[1]) : -1;
      chk("t2_word1", 32'(got), 32'h5A5A);
      chk("t2_tx_ready_pulses", 32'(ord_log.size()), 32'd2);
      chk("t2_wr_count", 32'(wr_count), 32'd2);
      chk("t2_fifoaddr", 32'(usb_fifoaddr), 32'h2);

      // Both directions eligible: bursts of two alternate, reads first
      clear_logs();
      for (int i = 0; i < 6; i++) ep2.push_back(16'h1000 + 16'(i));
      flaga_en = 1'b1;
      ok = 0;
      for (int i = 0; i < 20 && ok == 0; i++) begin
         run(1);
         if (busy) ok = 1;
      end
      chk("t3_read_started", 32'(ok), 32'd1);
      for (int i = 0; i < 6; i++) txq.push_back(16'h2000 + 16'(i));
      run(200);
      chk("t3_nxfers", 32'(ord_log.size()), 32'd12);
      for (int i = 0; i < 12; i++) begin
         got = (i < ord_log.size()) ? int'(ord_log[i]) : -1;
         chk("t3_order", 32'(got), 32'((i / 2) % 2));
      end
      for (int i = 0; i < 6; i++) begin
         got = (i < rx_log.size()) ? int'(rx_log[i]) : -1;
         chk("t3_rx_word", 32'(got), 32'h1000 + 32'(i));
         got = (i < ep6.size()) ? int'(ep6[i]) : -1;
         chk("t3_ep6_word", 32'(got), 32'h2000 + 32'(i));
      end
      chk("t3_rd_count", 32'(rd_count), 32'd9);
      chk("t3_wr_count", 32'(wr_count), 32'd8);

      // EP6 fills during the strobe of word 2
      clear_logs();
      base = wr_strobes;
      for (int i = 0; i < 4; i++) txq.push_back(16'h3000 + 16'(i));
      ok = 0;
      for (int i = 0; i < 100 && ok == 0; i++) begin
         run(1);
         if (wr_strobes - base >= 2) ok = 1;
      end
      chk("t4_second_strobe", 32'(ok), 32'd1);
      usb_flagc = 1'b0;
      run(40);
      chk("t4_nwords", 32'(ep6.size()), 32'd2);
      got = (ep6.size() > 1) ? int'(ep6[1]) : -1;
      chk("t4_word1", 32'(got), 32'h3001);
      chk("t4_busy", 32'(busy), 32'h0);
      chk("t4_wr_count", 32'(wr_count), 32'd10);
      chk("t4_left_in_client", 32'(txq.size()), 32'd2);
      tx_en = 1'b0;
      txq.delete();

      // Client not ready holds off reads; readiness starts one on the next edge
      clear_logs();
      rx_ready = 1'b0;
      ep2.push_back(16'h4000); ep2.push_back(16'h4001);
      run(20);
      chk("t5_no_strobe", 32'(slrd_runs.size() + slrd_run), 32'd0);
      chk("t5_idle", 32'(busy), 32'h0);
      rx_ready = 1'b1;
      @(posedge fpga_gclk);
      #2;
      chk("t5_grant_busy", 32'(busy), 32'h1);
      chk("t5_grant_sloe", 32'(usb_sloe), 32'h0);
      run(40);
      chk("t5_nwords", 32'(rx_log.size()), 32'd2);
      got = (rx_log.size() > 1) ? int'(rx_log[1]) : -1;
      chk("t5_word1", 32'(got), 32'h4001);
      chk("t5_rd_count", 32'(rd_count), 32'd11);

      // Asynchronous reset in the middle of a read strobe
      clear_logs();
      ep2.push_back(16'h5555);
      ok = 0;
      for (int i = 0; i < 30 && ok == 0; i++) begin
         run(1);
         if (!usb_slrd) ok = 1;
      end
      chk("t6_in_strobe", 32'(ok), 32'd1);
      #3;
      reset_n = 1'b0;
      flaga_en = 1'b0;
      ep2.delete();
      #1;
      chk("t6_slrd", 32'(usb_slrd), 32'h1);
      chk("t6_sloe", 32'(usb_sloe), 32'h1);
      chk("t6_slwr", 32'(usb_slwr), 32'h1);
      chk("t6_rd_count", 32'(rd_count), 32'h0);
      chk("t6_wr_count", 32'(wr_count), 32'h0);
      chk("t6_rx_valid", 32'(rx_valid), 32'h0);
      chk("t6_busy", 32'(busy), 32'h0);
      run(2);
      reset_n = 1'b1;
      run(20);
      chk("t6_no_rx", 32'(rx_log.size()), 32'd0);
      chk("t6_rd_count_after", 32'(rd_count), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
